// File: rtl/fpu_pkg.sv
// Shared FPU definitions: single-precision field layout and constants.
// Used by the int-to-float converter, comparator and arithmetic units.
package fpu_pkg;

    localparam int EXP_W         = 8;
    localparam int MANT_W        = 23;
    localparam int BIAS          = 127;
    localparam int ITOF_EXP_BASE = 158;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } float_t;

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter built as a binary merge tree.
// count is only meaningful when all_zero is clear.
module lzc32 (
    input  logic [31:0] data,
    output logic [4:0]  count,
    output logic        all_zero
);

    logic [15:0] z1;
    logic [0:0]  c1 [16];
    logic [7:0]  z2;
    logic [1:0]  c2 [8];
    logic [3:0]  z3;
    logic [2:0]  c3 [4];
    logic [1:0]  z4;
    logic [3:0]  c4 [2];

    // Each node: zero if both halves zero; count from the high half unless it is empty.
    for (genvar i = 0; i < 16; i++) begin : g_l1
        assign z1[i] = ~(data[2*i+1] | data[2*i]);
        assign c1[i] = ~data[2*i+1];
    end

    for (genvar i = 0; i < 8; i++) begin : g_l2
        assign z2[i] = z1[2*i+1] & z1[2*i];
        assign c2[i] = z1[2*i+1] ? {1'b1, c1[2*i]} : {1'b0, c1[2*i+1]};
    end

    for (genvar i = 0; i < 4; i++) begin : g_l3
        assign z3[i] = z2[2*i+1] & z2[2*i];
        assign c3[i] = z2[2*i+1] ? {1'b1, c2[2*i]} : {1'b0, c2[2*i+1]};
    end

    for (genvar i = 0; i < 2; i++) begin : g_l4
        assign z4[i] = z3[2*i+1] & z3[2*i];
        assign c4[i] = z3[2*i+1] ? {1'b1, c3[2*i]} : {1'b0, c3[2*i+1]};
    end

    assign all_zero = z4[1] & z4[0];
    assign count    = z4[1] ? {1'b1, c4[0]} : {1'b0, c4[1]};

endmodule

// File: rtl/fpu_itof.sv
// Two-stage signed int32 to single-precision converter with valid/ready.
// Define ITOF_ROUND_EN for round-to-nearest-even; otherwise truncates.
module fpu_itof
    import fpu_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_inexact
);

    logic             s1_valid;
    logic             s2_valid;
    logic             s1_adv;
    logic             s2_adv;
    logic             s1_sign;
    logic             s1_zero;
    logic [31:0]      s1_mag;
    logic [4:0]       s1_lz;
    logic [TAG_W-1:0] s1_tag;

    logic [31:0]      mag;
    logic [4:0]       lz;
    logic             all_zero;

    assign mag = in_data[31] ? (~in_data + 32'd1) : in_data;

    lzc32 u_lzc (
        .data     (mag),
        .count    (lz),
        .all_zero (all_zero)
    );

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    logic [30:0]       norm;
    logic [EXP_W-1:0]  exp_n;
    logic [MANT_W-1:0] mant_n;
    logic [MANT_W:0]   mant_r;
    logic              guard;
    logic              sticky;
    logic              inexact;
    float_t            res;

    always_comb begin
        norm    = 31'(s1_mag << s1_lz);
        exp_n   = EXP_W'(ITOF_EXP_BASE) - EXP_W'(s1_lz);
        mant_n  = norm[30:8];
        guard   = norm[7];
        sticky  = |norm[6:0];
        inexact = guard | sticky;
`ifdef ITOF_ROUND_EN
        mant_r  = {1'b0, mant_n} + (MANT_W+1)'(guard & (sticky | mant_n[0]));
`else
        mant_r  = {1'b0, mant_n};
`endif
        // A carry out leaves the mantissa field at zero and bumps the exponent.
        res.sign = s1_sign;
        res.exp  = exp_n + EXP_W'(mant_r[MANT_W]);
        res.mant = mant_r[MANT_W-1:0];
        if (s1_zero) begin
            res     = '0;
            inexact = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid    <= 1'b0;
            s1_sign     <= 1'b0;
            s1_zero     <= 1'b0;
            s1_mag      <= '0;
            s1_lz       <= '0;
            s1_tag      <= '0;
            s2_valid    <= 1'b0;
            out_data    <= '0;
            out_tag     <= '0;
            out_inexact <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_sign <= in_data[31];
                    s1_mag  <= mag;
                    s1_zero <= all_zero;
                    s1_lz   <= lz;
                    s1_tag  <= in_tag;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_data    <= res;
                    out_tag     <= s1_tag;
                    out_inexact <= inexact;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_itof.sv
// Directed and randomised checks for the int-to-float converter.
module tb_fpu_itof;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_inexact;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fpu_itof #(.TAG_W(5)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_tag     (out_tag),
        .out_inexact (out_inexact)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Independent reference: locate the MSB, shift right, round on the remainder.
    function automatic logic [32:0] ref_itof(input logic [31:0] x);
        logic [63:0] mag, m, rem, half;
        int p, sh;
        logic ix;
        mag = x[31] ? 64'(-x) : 64'(x);
        mag = mag & 64'hFFFF_FFFF;
        if (mag == 0) return 33'd0;
        p = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) p = i;
        ix = 1'b0;
        if (p <= 23) begin
            m = mag << (23 - p);
        end else begin
            sh   = p - 23;
            m    = mag >> sh;
            rem  = mag & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            ix   = (rem != 0);
`ifdef ITOF_ROUND_EN
            if (rem > half || (rem == half && m[0])) m = m + 1;
`endif
            if (m == (64'd1 << 24)) begin
                m = 64'd1 << 23;
                p = p + 1;
            end
        end
        return {ix, x[31], 8'(p + 127), m[22:0]};
    endfunction

    function automatic logic [31:0] rnd();
        logic [31:0] v;
        v = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) v = -v;
        return v;
    endfunction

    typedef struct {
        logic [31:0] din;
        logic [31:0] dout;
        logic        ix;
    } vec_t;

    vec_t vecs[14];

    task automatic send_one(input int idx, input vec_t v);
        in_valid  = 1'b1;
        in_data   = v.din;
        in_tag    = 5'(idx);
        out_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d in_ready", idx), 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d early_valid", idx), 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk($sformatf("v%0d result", idx),
            {24'd0, out_valid, out_inexact, out_tag, out_data},
            {24'd0, 1'b1, v.ix, 5'(idx), v.dout});
        @(posedge clk); #1;
    endtask

    logic [31:0] sv_vals[4];
    logic [31:0] got_data[$];
    logic [4:0]  got_tag[$];
    int          got_cyc[$];
    logic [32:0] q_exp[$];
    logic [4:0]  q_tag[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int k, sent, rcvd, notready, seen;
        logic [32:0] e;

        vecs[0]  = '{32'd1,          32'h3F80_0000, 1'b0};
        vecs[1]  = '{32'hFFFF_FFFF,  32'hBF80_0000, 1'b0};
        vecs[2]  = '{32'd0,          32'h0000_0000, 1'b0};
        vecs[3]  = '{32'h8000_0000,  32'hCF00_0000, 1'b0};
        vecs[4]  = '{32'd16777217,   32'h4B80_0000, 1'b1};
`ifdef ITOF_ROUND_EN
        vecs[5]  = '{32'd16777219,   32'h4B80_0002, 1'b1};
        vecs[6]  = '{32'h7FFF_FFFF,  32'h4F00_0000, 1'b1};
`else
        vecs[5]  = '{32'd16777219,   32'h4B80_0001, 1'b1};
        vecs[6]  = '{32'h7FFF_FFFF,  32'h4EFF_FFFF, 1'b1};
`endif
        vecs[7]  = '{32'd2,          32'h4000_0000, 1'b0};
        vecs[8]  = '{32'd3,          32'h4040_0000, 1'b0};
        vecs[9]  = '{32'd1000,       32'h447A_0000, 1'b0};
        vecs[10] = '{32'h00FF_FFFF,  32'h4B7F_FFFF, 1'b0};
        vecs[11] = '{32'hFF00_0000,  32'hCB80_0000, 1'b0};
        vecs[12] = '{32'hFFFF_FFFD,  32'hC040_0000, 1'b0};
        vecs[13] = '{32'h4000_0000,  32'h4E80_0000, 1'b0};

        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        #12;
        chk("reset outputs",
            {26'd0, out_valid, out_inexact, out_tag, out_data, in_ready},
            {26'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1});
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) send_one(i, vecs[i]);

        // Stall: four back-to-back operands against a blocked consumer.
        sv_vals[0] = 32'd100;
        sv_vals[1] = 32'd200;
        sv_vals[2] = -32'sd300;
        sv_vals[3] = 32'd16777219;
        k = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (k < 4);
            in_data  = sv_vals[k % 4];
            in_tag   = 5'(k + 1);
            @(negedge clk);
            if (in_valid && in_ready) k++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("stall accepts", 64'(k), 64'd2);
        chk("stall in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_valid = (k < 4);
            in_data  = sv_vals[k % 4];
            in_tag   = 5'(k + 1);
            @(negedge clk);
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_tag.push_back(out_tag);
                got_cyc.push_back(c);
            end
            if (in_valid && in_ready) k++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("stall count", 64'(got_tag.size()), 64'd4);
        for (int i = 0; i < 4 && i < got_tag.size(); i++) begin
            e = ref_itof(sv_vals[i]);
            chk($sformatf("stall item%0d", i),
                {27'd0, got_tag[i], got_data[i]}, {27'd0, 5'(i + 1), e[31:0]});
            if (i > 0)
                chk($sformatf("stall gap%0d", i), 64'(got_cyc[i] - got_cyc[i-1]), 64'd1);
        end

        // Full throughput with a reference-model scoreboard.
        sent = 0; rcvd = 0; notready = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = rnd();
        in_tag    = 5'd0;
        for (int c = 0; c < 140 && rcvd < 100; c++) begin
            @(negedge clk);
            if (in_valid && !in_ready) notready++;
            if (out_valid && out_ready) begin
                if (q_exp.size() == 0) begin
                    chk("thr spurious", 64'd1, 64'd0);
                end else begin
                    e = q_exp.pop_front();
                    chk($sformatf("thr r%0d", rcvd),
                        {26'd0, out_inexact, out_tag, out_data},
                        {26'd0, e[32], q_tag.pop_front(), e[31:0]});
                end
                rcvd++;
            end
            if (in_valid && in_ready) begin
                q_exp.push_back(ref_itof(in_data));
                q_tag.push_back(in_tag);
                sent++;
            end
            @(posedge clk); #1;
            if (sent < 100) begin
                in_data = rnd();
                in_tag  = 5'(sent);
            end else begin
                in_valid = 1'b0;
            end
        end
        chk("thr received", 64'(rcvd), 64'd100);
        chk("thr stalls", 64'(notready), 64'd0);

        // Reset with both stages full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'd7;
        in_tag    = 5'd5;
        k = 0;
        for (int c = 0; c < 6 && k < 2; c++) begin
            @(negedge clk);
            if (in_ready) k++;
            @(posedge clk); #1;
            in_data = 32'd8;
            in_tag  = 5'd6;
        end
        @(negedge clk);
        chk("pre-reset full", {62'd0, out_valid, in_ready}, {62'd0, 1'b1, 1'b0});
        @(posedge clk); #2;
        rstn     = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("reset drops valid", 64'(out_valid), 64'd0);
        @(negedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_data   = 32'd5;
        in_tag    = 5'd9;
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 8 && seen == 0; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                @(negedge clk);
            end
            if (out_valid) begin
                chk("post-reset first", {27'd0, out_tag, out_data},
                    {27'd0, 5'd9, 32'h40A0_0000});
                seen = 1;
            end
            @(posedge clk); #1;
        end
        chk("post-reset seen", 64'(seen), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
